// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 exception/interrupt controller:
// register indices, field positions, exception codes and packing helpers.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LSB     = 10;
    localparam int SR_IM_MSB     = 15;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_EXC_MSB = 6;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_IP_MSB  = 15;
    localparam int CAUSE_BD_BIT  = 31;

    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    function automatic logic [31:0] pack_sr(input logic [5:0] im,
                                            input logic       exl,
                                            input logic       ie);
        logic [31:0] v;
        v = '0;
        v[SR_IM_MSB:SR_IM_LSB] = im;
        v[SR_EXL_BIT]          = exl;
        v[SR_IE_BIT]           = ie;
        return v;
    endfunction

    function automatic logic [31:0] pack_cause(input logic       bd,
                                               input logic [5:0] ip,
                                               input logic [4:0] exc);
        logic [31:0] v;
        v = '0;
        v[CAUSE_BD_BIT]                = bd;
        v[CAUSE_IP_MSB:CAUSE_IP_LSB]   = ip;
        v[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = exc;
        return v;
    endfunction

endpackage

// File: rtl/cp0.sv
// Coprocessor-0 beside the M stage: holds SR/Cause/EPC/PRId, arbitrates
// interrupts against pipelined exceptions and raises the redirect request.
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID    = 32'h1234_5678,
    parameter logic [31:0] HANDLER = HANDLER_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_in,
    output logic [31:0] cp0_out,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic [31:0] epc_out
);

    if (HANDLER[1:0] != 2'b00) begin : g_handler_check
        $error("cp0: HANDLER must be word aligned");
    end

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] epc_target;

    // Interrupts win over exceptions; EXL masks both until eret.
    always_comb begin
        int_req    = (|(hw_int & im_q)) & ie_q & ~exl_q;
        exc_req    = (exc_code_in != 5'd0) & ~exl_q;
        req        = (int_req | exc_req) & reset;
        epc_target = bd_in ? (vpc - 32'd4) : vpc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        ip_d  = hw_int;
        exc_d = exc_q;
        epc_d = epc_q;

        if (req) begin
            // Taking the exception discards any coincident mtc0 or eret.
            exl_d = 1'b1;
            exc_d = int_req ? EXC_INT : exc_code_in;
            bd_d  = bd_in;
            epc_d = epc_target & 32'hFFFF_FFFC;
        end else begin
            if (en) begin
                case (cp0_addr)
                    REG_SR: begin
                        im_d  = cp0_in[SR_IM_MSB:SR_IM_LSB];
                        exl_d = cp0_in[SR_EXL_BIT];
                        ie_d  = cp0_in[SR_IE_BIT];
                    end
                    REG_EPC: epc_d = cp0_in;
                    default: ;
                endcase
            end
            if (eret) begin
                exl_d = 1'b0;
            end
        end
    end

    always_comb begin
        cp0_out = '0;
        case (cp0_addr)
            REG_SR:    cp0_out = pack_sr(im_q, exl_q, ie_q);
            REG_CAUSE: cp0_out = pack_cause(bd_q, ip_q, exc_q);
            REG_EPC:   cp0_out = epc_q;
            REG_PRID:  cp0_out = PRID;
            default:   cp0_out = '0;
        endcase
    end

    // An mtc0 EPC paired with eret must return to the freshly written address.
    always_comb begin
        epc_out = epc_q;
        if (en && (cp0_addr == REG_EPC) && !req) begin
            epc_out = cp0_in;
        end
    end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 exception/interrupt controller for the pipelined MIPS core. It sits beside the M stage and holds the SR, Cause, EPC and PRId registers. It arbitrates between hardware interrupts and the exception code carried down the pipeline, and drives `req`. `req` is the signal that redirects the program counter to handler address 0x0000_4180 and flushes the pipeline; `eret` returns execution via `epc_out`.

## Interface
Parameters:
- `PRID`, 32'h1234_5678: read-only value of register 15.
- `HANDLER`, 32'h0000_4180: handler address; informational here, the PC owns it.

Ports. Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `en` in 1: mtc0 write enable from the M stage.
- `cp0_addr` in 5: register index for mfc0/mtc0.
- `cp0_in` in 32: mtc0 write data (GPR rt).
- `cp0_out` out 32: mfc0 read data.
- `vpc` in 32: PC of the instruction currently in M.
- `bd_in` in 1: the M instruction sits in a branch delay slot.
- `exc_code_in` in 5: pipelined exception code; 0 means none.
- `hw_int` in 6: external interrupt lines, level-sensitive.
- `eret` in 1: eret is in M.
- `req` out 1: take exception/interrupt now (combinational).
- `epc_out` out 32: return address for eret.

## Operation
Registers and fields:
- SR (12): IM[15:10], EXL[1], IE[0]. All other bits read 0.
- Cause (13): BD[31], IP[15:10], ExcCode[6:2]. All other bits read 0.
- EPC (14): full 32 bits.
- PRId (15): `PRID`.
- Any other index reads 0, and writes to it are dropped.

Request logic:
- `int_req` = |(hw_int & SR.IM) & SR.IE & ~SR.EXL.
- `exc_req` = (exc_code_in != 0) & ~SR.EXL.
- `req` = (`int_req` | `exc_req`) & `reset`. Force `req` to 0 while `reset` is low.

On a clock edge with `req`=1:
- EXL <= 1.
- ExcCode <= 0 if `int_req`, else `exc_code_in`. Interrupt has priority over exception.
- BD <= `bd_in`.
- EPC <= (`bd_in` ? `vpc`-4 : `vpc`) with bits [1:0] forced to 00.
- A coincident mtc0 (`en`) is discarded.
- A coincident `eret` is ignored: EXL stays 1 and EPC takes the eret's `vpc`.

On a clock edge with `req`=0:
- `eret`=1: EXL <= 0.
- `en`=1: write `cp0_in` to the addressed register. SR writes only IM/EXL/IE. Cause is read-only to software. EPC writes all 32 bits.
- If `en` and `eret` coincide, apply both; EXL clears last.

Every edge, regardless of `req`: Cause.IP <= `hw_int`.

Read paths:
- `cp0_out` is a combinational read of the current register state.
- `epc_out` bypass: if `en` & `cp0_addr`==14 & ~`req`, then `epc_out` = `cp0_in`; otherwise `epc_out` = EPC.

## Timing
- Reset (async, `reset` low): SR=0, Cause=0, EPC=0, `req`=0, `cp0_out`=value of the addressed register (0 except PRId), `epc_out`=0.
- `req` has zero-cycle latency from `hw_int`, `exc_code_in` and SR. The PC samples it on the same edge and loads 0x4180 on that edge.
- Register updates become visible on the edge after the event. mfc0 in the following cycle sees the new value.
- EXL=1 masks all further requests, including nested exceptions, until the eret edge.
- An interrupt is pending the cycle after eret if `hw_int` is still asserted. `req` rises in that first cycle.
- `vpc`-4 uses 32-bit wrap-around; 0x0000_0000 gives 0xFFFF_FFFC.
- Reset deassertion is synchronized by the core reset tree. This block adds no extra cycles.

## Structure
- `cp0_pkg` holds:
  - register indices SR=12, CAUSE=13, EPC=14, PRID=15;
  - field bit positions;
  - ExcCode constants Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12;
  - handler address 0x0000_4180.
- Single module, no sub-module. The request/priority logic is a small combinational block inside `cp0`.

## Test plan
- Reset, then read each index via `cp0_addr`: reg 12/13/14 read 0, reg 15 reads `PRID`, `req`=0.
- mtc0 SR=0x0000_0401, then `hw_int`=6'b000001, `vpc`=0x3010, `bd_in`=0: `req`=1 that cycle. Next cycle EPC=0x3010, ExcCode=0, EXL=1, `req`=0.
- `exc_code_in`=12, `vpc`=0x3024, `bd_in`=1: `req`=1. After the edge, EPC=0x3020, BD=1, ExcCode=12.
- Simultaneous interrupt (IM/IE enabled) and `exc_code_in`=10: ExcCode=0 is recorded and `req` pulses once.
- mtc0 EPC=0x3100 with `eret` in the same cycle: `epc_out`=0x3100 combinationally, EXL cleared next cycle.
- Assert `reset` low mid-handler (EXL=1, EPC=0x3010): all registers 0 immediately without waiting for `clk`, and `req`=0.
